// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file with scoreboard:
// default geometry, init FSM state encoding and the hardwired-zero index.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // r0 is hardwired to zero: never stored, never reserved, never busy.
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/mips_rf_scoreboard.sv
// Per-register busy scoreboard. A reserve marks a register as having a
// pending multi-cycle producer; a write through the write port releases it.
// A same-cycle write to the reserved address counts as a release, so the
// new reserve is accepted and the register ends busy again.
module mips_rf_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run_i,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic                     rsv_ok_o,
    output logic [(2**ADDR_W)-1:0]   busy_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_rel;
    logic             eff_busy;

    assign wr_rel   = run_i & wr_en_i & (wr_addr_i != ZERO_A);
    assign eff_busy = busy_q[rsv_addr_i] & ~(wr_rel & (wr_addr_i == rsv_addr_i));
    assign rsv_ok_o = run_i & rsv_en_i & (rsv_addr_i != ZERO_A) & ~eff_busy;
    assign busy_o   = busy_q;

    // Next busy vector: release on write first, then a granted reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_rel) begin
            busy_d[wr_addr_i] = 1'b0;
        end
        if (rsv_ok_o) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy bits clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// Parametrised MIPS register file: NUM_RD combinational read ports with
// optional write-to-read bypass, one write port, a busy scoreboard for
// multi-cycle producers, and a post-reset sweep that zeroes every register
// so no preload is needed. The block is inert until the sweep completes.
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ok,
    output logic                       init_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic BYP_EN = (BYPASS != 0);

    rf_state_e          state_q;
    rf_state_e          state_d;
    logic [ADDR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0]  ptr_d;
    logic [DATA_W-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic               run;
    logic               wr_ok;

    assign run       = (state_q == RF_RUN);
    assign init_done = run;
    assign wr_ok     = run & wr_en & (wr_addr != ZERO_A);

    // Sweep sequencing: walk every index once, then hand over to RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == RF_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_A) begin
                state_d = RF_RUN;
            end
        end
    end

    // Control state resets asynchronously; a mid-sweep reset restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage: zeroed by the sweep during INIT, written by the port in RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs_q[ptr_q] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    mips_rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .rsv_ok_o   (rsv_ok),
        .busy_o     (busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit = BYP_EN & wr_ok & (wr_addr == ra);

        // Read port: zero register and INIT read as idle zero, bypass beats storage.
        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = '0;
            rd_busy[i]                  = 1'b0;
            if (run && (ra != ZERO_A)) begin
                if (hit) begin
                    rd_data[i*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
                    rd_busy[i]                  = busy[ra];
                end
            end
        end
    end

endmodule
